// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Used by both the controller and the iterative divider core.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } mdu_state_t;

    localparam int unsigned DIV_ITERS_DEFAULT = 32;
    localparam logic [31:0] DIV0_LO           = 32'hFFFF_FFFF;

    // Two's-complement magnitude, applied only when the operation is signed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per cycle.
// done pulses on the last iteration while quotient/remainder show that step's result.
module div_radix2
    import mdu_pkg::*;
#(
    parameter int unsigned ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        running;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    always_comb begin
        shifted   = {rem, quo[31]};
        diff      = shifted - {1'b0, dsr};
        fits      = ~diff[32];
        quotient  = {quo[30:0], fits};
        remainder = fits ? diff[31:0] : shifted[31:0];
        done      = running && (cnt == 6'(ITERS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            cnt <= cnt + 6'd1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded by start before use.
    always_ff @(posedge clk) begin
        if (start) begin
            rem <= '0;
            quo <= dividend;
            dsr <= divisor;
        end else if (running) begin
            rem <= remainder;
            quo <= quotient;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// Holds E with stall_o until the {HI,LO} result is ready, then presents it until the pipe advances.
module muldiv_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        E_valid,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_a,
    input  logic [31:0] E_b,
    input  logic        pipe_adv,
    input  logic        flush,
    output logic        stall_o,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [63:0] hilo_o
);

    mdu_op_t    op;
    mdu_state_t state;
    mdu_state_t state_next;

    logic        req;
    logic        start;
    logic        is_mul;
    logic        signed_op;
    logic        div_by_zero;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mul_signed;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    assign op = mdu_op_t'(E_op);

    always_comb begin
        req         = E_valid && (op != MDU_NONE);
        start       = (state == ST_IDLE) && req && !flush;
        is_mul      = (op == MDU_MULT) || (op == MDU_MULTU);
        signed_op   = (op == MDU_MULT) || (op == MDU_DIV);
        div_by_zero = !is_mul && (E_b == 32'd0);
        div_start   = start && !is_mul && !div_by_zero;
    end

    div_radix2 #(
        .ITERS(DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (mag32(E_a, signed_op)),
        .divisor   (mag32(E_b, signed_op)),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Extending both operands to 64 bits makes one unsigned multiplier serve both signednesses.
    always_comb begin
        ext_a   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        ext_b   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        product = ext_a * ext_b;
        q_fix   = neg_q ? (~div_q + 32'd1) : div_q;
        r_fix   = neg_r ? (~div_r + 32'd1) : div_r;
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_a       <= E_a;
            op_b       <= E_b;
            mul_signed <= signed_op;
            neg_q      <= signed_op && (E_a[31] ^ E_b[31]);
            neg_r      <= signed_op && E_a[31];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = is_mul ? ST_MUL : (div_by_zero ? ST_DONE : ST_DIV);
            ST_MUL:  state_next = ST_DONE;
            ST_DIV:  if (div_done) state_next = ST_DONE;
            ST_DONE: if (pipe_adv) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        busy_o         = (state != ST_IDLE);
        result_valid_o = (state == ST_DONE);
        stall_o        = req && (state != ST_DONE) && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hilo_o <= '0;
        end else if (start && div_by_zero) begin
            hilo_o <= {E_a, DIV0_LO};
        end else if (!flush && (state == ST_MUL)) begin
            hilo_o <= product;
        end else if (!flush && (state == ST_DIV) && div_done) begin
            hilo_o <= {r_fix, q_fix};
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results, latencies and stall counts.
module tb_muldiv_ctrl;
    import mdu_pkg::*;

    localparam int ITERS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        E_valid;
    logic [2:0]  E_op;
    logic [31:0] E_a;
    logic [31:0] E_b;
    logic        pipe_adv;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [63:0] hilo_o;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .DIV_ITERS(ITERS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .E_valid        (E_valid),
        .E_op           (E_op),
        .E_a            (E_a),
        .E_b            (E_b),
        .pipe_adv       (pipe_adv),
        .flush          (flush),
        .stall_o        (stall_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .hilo_o         (hilo_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic definition.
    function automatic logic [63:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa;
        int     sb;
        int     q;
        int     r;
        sa = a;
        sb = b;
        case (op)
            MDU_MULT: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            MDU_MULTU: return {32'd0, a} * {32'd0, b};
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            MDU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Reference model: idle / computing (with cycles left) / holding a result.
    bit          m_live = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_hilo = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_live <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hilo <= '0;
        end else if (!m_live) begin
            m_busy <= 1'b0;
        end else if (flush) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (m_done) begin
            if (pipe_adv) m_done <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_hilo <= m_pend;
            end
        end else if (E_valid && E_op != MDU_NONE) begin
            if ((E_op == MDU_DIV || E_op == MDU_DIVU) && E_b == 32'd0) begin
                m_done <= 1'b1;
                m_hilo <= golden(E_op, E_a, E_b);
            end else begin
                m_busy <= 1'b1;
                m_pend <= golden(E_op, E_a, E_b);
                m_left <= (E_op == MDU_MULT || E_op == MDU_MULTU) ? 1 : ITERS;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("stall", stall_o, E_valid && E_op != MDU_NONE && !m_done && !flush);
            check("busy", busy_o, m_busy || m_done);
            check("valid", result_valid_o, m_done);
            check("hilo", hilo_o, m_hilo);
            if (stall_o) stall_cnt++;
        end
    end

    // Issue one op, hold E until the result shows, keep DONE for 'hold' extra cycles, then advance.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input int exp_lat,
                          input logic [63:0] exp_hilo);
        int cyc;
        int s0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        E_valid  = 1'b1;
        E_op     = op;
        E_a      = a;
        E_b      = b;
        pipe_adv = 1'b0;
        s0       = stall_cnt;
        cyc      = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (result_valid_o) break;
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({name, "_result"}, hilo_o, exp_hilo);
        check({name, "_model"}, m_hilo, exp_hilo);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_hilo"}, hilo_o, exp_hilo);
            check({name, "_hold_stall"}, stall_o, 1'b0);
        end
        @(posedge clk);
        #1 pipe_adv = 1'b1;
        @(posedge clk);
        #1;
        pipe_adv = 1'b0;
        E_valid  = 1'b0;
        E_op     = MDU_NONE;
        @(negedge clk);
        check({name, "_idle"}, busy_o, 1'b0);
        check({name, "_stall_cycles"}, 64'(stall_cnt - s0), 64'(exp_lat));
    endtask

    initial begin
        rst      = 1'b1;
        E_valid  = 1'b0;
        E_op     = MDU_NONE;
        E_a      = '0;
        E_b      = '0;
        pipe_adv = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy_o, 1'b0);
        check("reset_valid", result_valid_o, 1'b0);
        check("reset_hilo", hilo_o, 64'd0);

        run_op("mult_m5x3", MDU_MULT, 32'hFFFF_FFFB, 32'd3, 0, 2, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 0, 33, 64'h0000_0002_0000_000E);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 0, 33, 64'h0000_0001_FFFF_FFFD);
        run_op("div_m7_m2", MDU_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 33, 64'hFFFF_FFFF_0000_0003);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 64'h0000_0000_8000_0000);
        run_op("divu_big", MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 0, 33, 64'h0000_000F_0FFF_FFFF);
        run_op("divu_by0", MDU_DIVU, 32'h0000_1234, 32'd0, 0, 1, 64'h0000_1234_FFFF_FFFF);
        run_op("div_by0", MDU_DIV, 32'hFFFF_FFFF, 32'd0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);

        // A valid instruction that is not a multiply/divide must neither stall nor start.
        @(posedge clk);
        #1;
        E_valid = 1'b1;
        E_op    = MDU_NONE;
        @(negedge clk);
        check("none_stall", stall_o, 1'b0);
        check("none_busy", busy_o, 1'b0);
        @(posedge clk);
        #1 E_valid = 1'b0;

        // DIV killed by a flush at T+10; a MULT issued at T+11 must run normally.
        @(posedge clk);
        #1;
        E_valid = 1'b1;
        E_op    = MDU_DIV;
        E_a     = 32'd1000;
        E_b     = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_stall", stall_o, 1'b0);
        check("flush_busy_before", busy_o, 1'b1);
        run_op("mult_after_flush", MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 0, 2, 64'hC000_0000_8000_0000);

        run_op("multu_hold", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 3, 2, 64'h0000_0001_FFFF_FFFE);

        // Reset in the middle of a divide clears everything at the next edge.
        @(posedge clk);
        #1;
        E_valid = 1'b1;
        E_op    = MDU_DIV;
        E_a     = 32'd50;
        E_b     = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        rst     = 1'b1;
        E_valid = 1'b0;
        E_op    = MDU_NONE;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy_o, 1'b0);
        check("midreset_valid", result_valid_o, 1'b0);
        check("midreset_hilo", hilo_o, 64'd0);

        run_op("divu_after_reset", MDU_DIVU, 32'd50, 32'd5, 0, 33, 64'h0000_0000_0000_000A);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
